// File: rtl/senha_entrada.sv
`default_nettype none
// ============================================================================
// Module   : senha_entrada
// Purpose  : Password entry buffer for the lock's operational mode; holds up
//            to six keypad digits and drives a masked display packet.
// Revision : 1.0 - initial release
// ============================================================================

package senha_entrada_pkg;
    typedef struct packed {
        logic [3:0] BCD5;
        logic [3:0] BCD4;
        logic [3:0] BCD3;
        logic [3:0] BCD2;
        logic [3:0] BCD1;
        logic [3:0] BCD0;
    } bcdPac_t;
endpackage

module senha_entrada
    import senha_entrada_pkg::*;
#(
    parameter int MASK_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bloqueado,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clear,
    input  logic       confirm,
    output bcdPac_t    bcd_packet_operacional,
    output logic       enable_o,
    output bcdPac_t    senha,
    output logic [2:0] senha_len,
    output logic       senha_valid,
    output logic       timeout
);

    localparam int MW = (MASK_CYCLES > 1) ? $clog2(MASK_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [MW-1:0] c_mask_last = MW'(MASK_CYCLES - 1);
    localparam logic [TW-1:0] c_to_last   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]   c_all_blank = {6{4'hB}};
    localparam logic [23:0]   c_all_dash  = {6{4'hA}};

    typedef enum logic [1:0] {
        VAZIO   = 2'd0,
        ENTRADA = 2'd1,
        ENVIO   = 2'd2,
        BLOQ    = 2'd3
    } state_t;

    state_t        r_state, w_next_state;
    logic [23:0]   r_senha, w_buf;
    logic [23:0]   r_packet, w_pkt;
    logic [2:0]    r_len, w_len;
    logic          r_masked, w_masked;
    logic [MW-1:0] r_mask_cnt, w_mask_cnt;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic          r_enable, r_valid, r_timeout;
    logic          w_valid, w_timeout, w_accept;

    assign w_accept = digit_valid && (digit <= 4'd9) && (r_len < 3'd6);

    always_comb begin
        w_next_state = r_state;
        w_buf        = r_senha;
        w_len        = r_len;
        w_masked     = r_masked;
        w_mask_cnt   = r_mask_cnt;
        w_to_cnt     = r_to_cnt;
        w_valid      = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            BLOQ: begin
                if (!bloqueado)
                    w_next_state = VAZIO;
            end
            ENVIO: begin
                w_next_state = VAZIO;
                w_buf        = c_all_blank;
                w_len        = 3'd0;
            end
            default: begin
                if (clear) begin
                    w_next_state = VAZIO;
                    w_buf        = c_all_blank;
                    w_len        = 3'd0;
                end else if (confirm && (r_len != 3'd0)) begin
                    w_next_state = ENVIO;
                    w_valid      = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ENTRADA;
                    w_buf        = {r_senha[19:0], digit};
                    w_len        = r_len + 3'd1;
                    w_masked     = 1'b0;
                    w_mask_cnt   = '0;
                    w_to_cnt     = '0;
                end else if (r_state == ENTRADA) begin
                    if (r_to_cnt == c_to_last) begin
                        w_next_state = VAZIO;
                        w_buf        = c_all_blank;
                        w_len        = 3'd0;
                        w_timeout    = 1'b1;
                    end else begin
                        w_to_cnt = r_to_cnt + TW'(1);
                        // Mask counter stops once the newest digit is hidden
                        if (!r_masked) begin
                            if (r_mask_cnt == c_mask_last)
                                w_masked = 1'b1;
                            else
                                w_mask_cnt = r_mask_cnt + MW'(1);
                        end
                    end
                end
            end
        endcase

        if (bloqueado) begin
            w_next_state = BLOQ;
            w_buf        = c_all_blank;
            w_len        = 3'd0;
            w_valid      = 1'b0;
            w_timeout    = 1'b0;
        end

        if (w_next_state == VAZIO || w_next_state == BLOQ) begin
            w_masked   = 1'b0;
            w_mask_cnt = '0;
            w_to_cnt   = '0;
        end
    end

    // Display: the packet is frozen while the entry is being submitted
    always_comb begin
        w_pkt = c_all_blank;
        if (w_next_state == BLOQ) begin
            w_pkt = c_all_dash;
        end else if (w_next_state == ENVIO) begin
            w_pkt = r_packet;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (3'(i) < w_len)
                    w_pkt[i*4 +: 4] = (i == 0 && !w_masked) ? w_buf[3:0] : 4'hA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= VAZIO;
            r_senha    <= c_all_blank;
            r_packet   <= c_all_blank;
            r_len      <= 3'd0;
            r_masked   <= 1'b0;
            r_mask_cnt <= '0;
            r_to_cnt   <= '0;
            r_enable   <= 1'b0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_senha    <= w_buf;
            r_packet   <= w_pkt;
            r_len      <= w_len;
            r_masked   <= w_masked;
            r_mask_cnt <= w_mask_cnt;
            r_to_cnt   <= w_to_cnt;
            r_enable   <= (w_pkt != r_packet);
            r_valid    <= w_valid;
            r_timeout  <= w_timeout;
        end
    end

    assign bcd_packet_operacional = bcdPac_t'(r_packet);
    assign senha                  = bcdPac_t'(r_senha);
    assign senha_len              = r_len;
    assign enable_o               = r_enable;
    assign senha_valid            = r_valid;
    assign timeout                = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_senha_entrada.sv
`default_nettype none
// ============================================================================
// Module   : tb_senha_entrada
// Purpose  : Directed self-checking bench for senha_entrada.
// Revision : 1.0 - initial release
// ============================================================================

module tb_senha_entrada;
    import senha_entrada_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bloqueado;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       confirm;
    bcdPac_t    pkt;
    logic       enable_o;
    bcdPac_t    senha;
    logic [2:0] senha_len;
    logic       senha_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int val_cnt = 0;
    int e0, v0;

    senha_entrada #(.MASK_CYCLES(20), .TIMEOUT_CYCLES(50)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .bloqueado              (bloqueado),
        .digit_valid            (digit_valid),
        .digit                  (digit),
        .clear                  (clear),
        .confirm                (confirm),
        .bcd_packet_operacional (pkt),
        .enable_o               (enable_o),
        .senha                  (senha),
        .senha_len              (senha_len),
        .senha_valid            (senha_valid),
        .timeout                (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (enable_o)    en_cnt++;
        if (senha_valid) val_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        cyc(1);
        digit_valid = 1'b0;
    endtask

    task automatic strobe_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bloqueado = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        clear = 1'b0; confirm = 1'b0;
        #3;
        chk("rst_pkt",   pkt,         24'hBBBBBB);
        chk("rst_senha", senha,       24'hBBBBBB);
        chk("rst_len",   senha_len,   3'd0);
        chk("rst_en",    enable_o,    1'b0);
        chk("rst_valid", senha_valid, 1'b0);
        chk("rst_to",    timeout,     1'b0);
        cyc(1);
        rst = 1'b0;
        cyc(2);

        e0 = en_cnt;
        press(4'd1);
        chk("d1_pkt", pkt, 24'hBBBBB1);
        cyc(4);
        press(4'd2);
        chk("d2_pkt", pkt, 24'hBBBBA2);
        cyc(4);
        press(4'd3);
        chk("d3_pkt", pkt, 24'hBBBAA3);
        chk("d3_len", senha_len, 3'd3);
        cyc(19);
        chk("pre_mask_pkt", pkt, 24'hBBBAA3);
        cyc(1);
        chk("mask_pkt", pkt, 24'hBBBAAA);
        chk("mask_en",  enable_o, 1'b1);
        cyc(2);
        chk("en_count", en_cnt - e0, 4);
        strobe_clear();
        chk("clr_pkt", pkt, 24'hBBBBBB);
        chk("clr_len", senha_len, 3'd0);

        for (int i = 1; i <= 7; i++) press(4'(i));
        chk("full_len",   senha_len, 3'd6);
        chk("full_senha", senha, 24'h123456);
        chk("full_pkt",   pkt, 24'hAAAAA6);
        chk("d7_no_en",   enable_o, 1'b0);
        press(4'hC);
        chk("keyC_len",   senha_len, 3'd6);
        chk("keyC_senha", senha, 24'h123456);
        strobe_clear();

        v0 = val_cnt;
        press(4'd4);
        press(4'd5);
        confirm = 1'b1;
        cyc(1);
        confirm = 1'b0;
        chk("cf_valid", senha_valid, 1'b1);
        chk("cf_len",   senha_len, 3'd2);
        chk("cf_senha", senha, 24'hBBBB45);
        cyc(1);
        chk("cf2_valid", senha_valid, 1'b0);
        chk("cf2_len",   senha_len, 3'd0);
        chk("cf2_pkt",   pkt, 24'hBBBBBB);
        chk("cf2_en",    enable_o, 1'b1);
        cyc(2);
        chk("cf_pulses", val_cnt - v0, 1);
        v0 = val_cnt;
        confirm = 1'b1;
        cyc(1);
        confirm = 1'b0;
        cyc(2);
        chk("cf_empty", val_cnt - v0, 0);

        press(4'd8);
        confirm = 1'b1; digit_valid = 1'b1; digit = 4'd9;
        cyc(1);
        confirm = 1'b0; digit_valid = 1'b0;
        chk("pri_valid", senha_valid, 1'b1);
        chk("pri_len",   senha_len, 3'd1);
        chk("pri_senha", senha, 24'hBBBBB8);
        cyc(2);
        v0 = val_cnt;
        press(4'd3);
        clear = 1'b1; confirm = 1'b1;
        cyc(1);
        clear = 1'b0; confirm = 1'b0;
        chk("clrcf_valid", senha_valid, 1'b0);
        chk("clrcf_len",   senha_len, 3'd0);
        chk("clrcf_pkt",   pkt, 24'hBBBBBB);
        cyc(2);
        chk("clrcf_pulses", val_cnt - v0, 0);

        press(4'd9);
        cyc(49);
        chk("to_early", timeout, 1'b0);
        chk("to_len_early", senha_len, 3'd1);
        cyc(1);
        chk("to_pulse", timeout, 1'b1);
        chk("to_pkt",   pkt, 24'hBBBBBB);
        chk("to_len",   senha_len, 3'd0);
        cyc(1);
        chk("to_once",  timeout, 1'b0);

        press(4'd2);
        press(4'd3);
        bloqueado = 1'b1;
        cyc(1);
        chk("blq_pkt", pkt, 24'hAAAAAA);
        chk("blq_len", senha_len, 3'd0);
        press(4'd5);
        chk("blq_dig_pkt", pkt, 24'hAAAAAA);
        chk("blq_dig_len", senha_len, 3'd0);
        chk("blq_dig_en",  enable_o, 1'b0);
        bloqueado = 1'b0;
        cyc(1);
        chk("unblq_pkt", pkt, 24'hBBBBBB);
        chk("unblq_en",  enable_o, 1'b1);

        press(4'd1);
        press(4'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pkt",   pkt, 24'hBBBBBB);
        chk("arst_senha", senha, 24'hBBBBBB);
        chk("arst_len",   senha_len, 3'd0);
        chk("arst_en",    enable_o, 1'b0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/senha_entrada.md
# senha_entrada

Password entry buffer for the electronic lock's operational mode. It accepts debounced keypad digit pulses and holds up to six digits. It drives the display stage with a masked `bcdPac_t` packet and a load strobe. On confirm, it presents the entered code to the lock controller and clears itself.

## Interface
Parameters:
- `MASK_CYCLES`, default 50_000_000: cycles the newest digit is shown as a numeral before being masked.
- `TIMEOUT_CYCLES`, default 250_000_000: inactivity cycles after which a partial entry is discarded.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `bloqueado`  in  1  lock-out from the controller. While high, all keypad inputs are ignored and the display shows all dashes.
- `digit_valid`  in  1  one-cycle keypad strobe.
- `digit`  in  4  key code; valid with `digit_valid`.
- `clear`  in  1  one-cycle strobe that discards the entry.
- `confirm`  in  1  one-cycle strobe that submits the entry.
- `bcd_packet_operacional`  out  `bcdPac_t` (24)  display packet; `BCD0` = rightmost position.
- `enable_o`  out  1  one-cycle strobe, high in the cycle a new packet value is first visible.
- `senha`  out  `bcdPac_t` (24)  raw entered digits. `BCD0` holds the newest digit; unused positions hold 4'hB.
- `senha_len`  out  3  number of digits held, 0..6.
- `senha_valid`  out  1  one-cycle pulse. `senha`/`senha_len` are stable while it is high.
- `timeout`  out  1  one-cycle pulse when an entry is discarded by inactivity.

## Operation
- Glyph codes:
  - 4'h0-4'h9: numeral.
  - 4'hA: dash.
  - 4'hB: blank.
- FSM states:
  - VAZIO: len 0.
  - ENTRADA: len 1..6.
  - ENVIO: single cycle.
  - BLOQ.
- Reset:
  - State goes to VAZIO.
  - All `bcd_packet_operacional` and `senha` nibbles go to 4'hB.
  - `senha_len`=0; `enable_o`, `senha_valid`, `timeout` = 0.
  - Counters go to 0.
- Digit acceptance:
  - `digit_valid` with `digit` ≤ 9 and `senha_len` < 6 shifts the digits up one position (`BCD5`←`BCD4` … `BCD1`←`BCD0`) and sets `BCD0`←`digit`.
  - `senha_len` increments; the mask counter and timeout counter clear.
  - VAZIO→ENTRADA.
- Ignored keys:
  - `digit` ≥ 4'hA: ignored, no state change.
  - Sixth digit already held (full): further digits ignored, buffer unchanged.
- Display packet:
  - Empty: all positions blank.
  - Newest digit unmasked: `BCD0` shows the numeral.
  - Newest digit masked, or not the newest: position shows a dash.
  - Positions ≥ `senha_len` are blank.
  - The newest digit becomes masked when the mask counter reaches `MASK_CYCLES`-1, or when a new digit arrives (the previous digit is shown as a dash at once).
- Confirm:
  - `confirm` with `senha_len` ≥ 1: go to ENVIO.
  - In ENVIO, `senha_valid`=1 with `senha`/`senha_len` holding the entry.
  - Next cycle: buffer cleared to VAZIO, display blank.
  - `confirm` with `senha_len`=0 is ignored.
- Clear: `clear` in ENTRADA → VAZIO, buffer blank. No `senha_valid`, no `timeout`.
- Timeout:
  - In ENTRADA the timeout counter increments each cycle.
  - At `TIMEOUT_CYCLES`-1 → VAZIO, buffer cleared, `timeout` pulses once.
  - The counter does not run in VAZIO.
- Lock-out:
  - `bloqueado` rising, from any state: buffer cleared, go to BLOQ, all display positions 4'hA.
  - `bloqueado` falling: → VAZIO (blank display).
- Priority within a cycle: `bloqueado` > `clear` > `confirm` > `digit_valid` > timeout expiry.
  - Losing strobes are discarded, not queued.

## Timing
- All outputs are registered.
- Latency for every event (digit, clear, confirm, timeout, mask expiry, lock-out): the effect is visible 1 cycle after the sampling edge.
- `enable_o` is high exactly in that cycle, and only if `bcd_packet_operacional` changed value. No pulse for an ignored event or an unchanged packet.
- Masking timing:
  - A digit accepted at edge k shows as a numeral from k+1.
  - It shows as a dash from k+`MASK_CYCLES`+1, unless superseded earlier.
- Confirm timing:
  - `confirm` at edge k: `senha_valid` high during cycle k+1.
  - At k+2: `senha_len`=0, packet blank, `enable_o`=1.
- Counters are sized to `$clog2` of the parameter. They saturate and must not wrap.
- `rst` mid-entry or in ENVIO aborts immediately: no `senha_valid`, no `timeout`.

## Test plan
- Reset, then digits 1,2,3 (one per 5 cycles, `MASK_CYCLES`=20) → `BCD0`=3, `BCD1`=A, `BCD2`=A, `BCD3..5`=B; `senha_len`=3; one `enable_o` per digit. After 20 idle cycles → `BCD0`=A with one `enable_o`.
- Enter 7 digits 1..7 → `senha_len`=6, `senha.BCD0`=6, `senha.BCD5`=1; 7th digit produces no `enable_o`. Digit 4'hC is also ignored.
- Enter 4,5 then `confirm` → `senha_valid` for exactly 1 cycle with `senha_len`=2, `senha.BCD0`=5, `senha.BCD1`=4. Next cycle: all B, `senha_len`=0. `confirm` while empty → no pulse.
- `confirm` and `digit_valid` in the same cycle with 1 digit held → `senha_valid`, digit dropped. `clear`+`confirm` together → cleared, no `senha_valid`.
- `TIMEOUT_CYCLES`=50, enter 9, idle → `timeout` pulses 50 cycles after acceptance; display all B.
- `bloqueado`=1 mid-entry → all A, digits ignored. `bloqueado`=0 → all B, `senha_len`=0. `rst` asserted mid-entry → all outputs at reset values asynchronously.
